// File: rtl/register_file_pkg.sv
// Shared configuration for the CPU register file: default geometry, clock period
// and the index of the hardwired zero register.
package register_file_pkg;

  localparam int RF_ADDR_WIDTH = 5;
  localparam int RF_DATA_WIDTH = 32;
  localparam int RF_RATE       = 10;
  localparam int RF_REG_ZERO   = 0;
  localparam int RF_NUM_PORTS  = 3;

  typedef enum int {
    PORT_A = 0,
    PORT_B = 1,
    PORT_C = 2
  } rf_port_e;

endpackage

// File: rtl/register_file_read_port.sv
// One combinational register-file read port.
// It selects a word by address and forces the zero register to read as 0.
module register_file_read_port
  import register_file_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int DATA_WIDTH = RF_DATA_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0]                     addr_i,
  input  logic [2**ADDR_WIDTH-1:0][DATA_WIDTH-1:0]  regs_i,
  output logic [DATA_WIDTH-1:0]                     data_o
);

  assign data_o = (addr_i == ADDR_WIDTH'(RF_REG_ZERO)) ? '0 : regs_i[addr_i];

endmodule

// File: rtl/register_file.sv
// CPU general-purpose register file with three combinational read ports (rs, rt, rd)
// and one synchronous write port addressed by rd. Register 0 always reads 0.
module register_file
  import register_file_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int DATA_WIDTH = RF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [ADDR_WIDTH-1:0] addr_c,
  input  logic [DATA_WIDTH-1:0] data_c,
  input  logic                  we,
  output logic [DATA_WIDTH-1:0] q_a,
  output logic [DATA_WIDTH-1:0] q_b,
  output logic [DATA_WIDTH-1:0] q_c
);

  localparam int NUM_REGS = 2**ADDR_WIDTH;

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] mem_q;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] mem_d;

  logic [ADDR_WIDTH-1:0] rd_addr [RF_NUM_PORTS];
  logic [DATA_WIDTH-1:0] rd_data [RF_NUM_PORTS];

  // Writes to the zero register are dropped here so its storage stays at 0.
  always_comb begin
    mem_d = mem_q;
    if (we && (addr_c != ADDR_WIDTH'(RF_REG_ZERO))) begin
      mem_d[addr_c] = data_c;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_addr[PORT_A] = addr_a;
  assign rd_addr[PORT_B] = addr_b;
  assign rd_addr[PORT_C] = addr_c;

  genvar gi;
  generate
    for (gi = 0; gi < RF_NUM_PORTS; gi++) begin : g_read_port
      register_file_read_port #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
      ) u_read_port (
        .addr_i (rd_addr[gi]),
        .regs_i (mem_q),
        .data_o (rd_data[gi])
      );
    end
  endgenerate

  assign q_a = rd_data[PORT_A];
  assign q_b = rd_data[PORT_B];
  assign q_c = rd_data[PORT_C];

endmodule

// File: tb/tb_register_file.sv
// Directed, table-driven bench for register_file: write/readback vectors plus
// hand sequences for the pre-edge view and asynchronous reset.
module tb_register_file;
  import register_file_pkg::*;

  localparam int AW = RF_ADDR_WIDTH;
  localparam int DW = RF_DATA_WIDTH;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] addr_a, addr_b, addr_c;
  logic [DW-1:0] data_c;
  logic          we;
  logic [DW-1:0] q_a, q_b, q_c;

  int checks   = 0;
  int failures = 0;

  always #(RF_RATE/2) clk = ~clk;

  register_file dut (
    .clk    (clk),
    .reset  (reset),
    .addr_a (addr_a),
    .addr_b (addr_b),
    .addr_c (addr_c),
    .data_c (data_c),
    .we     (we),
    .q_a    (q_a),
    .q_b    (q_b),
    .q_c    (q_c)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] a, b, c;
    logic [DW-1:0] d;
    logic [DW-1:0] pre_a, pre_b, pre_c;
    logic [DW-1:0] post_a, post_b, post_c;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [AW-1:0] a, input logic [AW-1:0] b,
                       input logic [AW-1:0] c, input logic [DW-1:0] d);
    we = w; addr_a = a; addr_b = b; addr_c = c; data_c = d;
  endtask

  initial begin
    // we, a, b, c, data, pre(a,b,c), post(a,b,c)
    vecs[0] = '{1'b1,  2,  5,  6, 32'd39,        0, 0, 0,                       0, 0, 32'd39};
    vecs[1] = '{1'b0,  6,  3,  9, 32'd589,       32'd39, 0, 0,                  32'd39, 0, 0};
    vecs[2] = '{1'b0,  6,  3,  9, 32'd589,       32'd39, 0, 0,                  32'd39, 0, 0};
    vecs[3] = '{1'b1,  0,  6,  0, 32'hDEADBEEF,  0, 32'd39, 0,                  0, 32'd39, 0};
    vecs[4] = '{1'b1, 17, 17, 17, 32'h1234,      0, 0, 0,                       32'h1234, 32'h1234, 32'h1234};
    vecs[5] = '{1'b0, 17, 17, 17, 32'hFFFF,      32'h1234, 32'h1234, 32'h1234,  32'h1234, 32'h1234, 32'h1234};
    vecs[6] = '{1'b1, 31,  6, 31, 32'hA5A5A5A5,  0, 32'd39, 0,                  32'hA5A5A5A5, 32'd39, 32'hA5A5A5A5};
    vecs[7] = '{1'b1, 31,  6,  6, 32'd77,        32'hA5A5A5A5, 32'd39, 32'd39,  32'hA5A5A5A5, 32'd77, 32'd77};
    vecs[8] = '{1'b1,  6, 31,  6, 32'd39,        32'd77, 32'hA5A5A5A5, 32'd77,  32'd39, 32'hA5A5A5A5, 32'd39};

    reset = 1'b1;
    drive(1'b0, 0, 5, 31, 32'd0);
    @(posedge clk); #1;
    chk("reset_q_a", q_a, 0);
    chk("reset_q_b", q_b, 0);
    chk("reset_q_c", q_c, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].we, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d);
      #1;
      chk($sformatf("v%0d_pre_q_a", i), q_a, vecs[i].pre_a);
      chk($sformatf("v%0d_pre_q_b", i), q_b, vecs[i].pre_b);
      chk($sformatf("v%0d_pre_q_c", i), q_c, vecs[i].pre_c);
      @(posedge clk); #1;
      chk($sformatf("v%0d_post_q_a", i), q_a, vecs[i].post_a);
      chk($sformatf("v%0d_post_q_b", i), q_b, vecs[i].post_b);
      chk($sformatf("v%0d_post_q_c", i), q_c, vecs[i].post_c);
      $display("vec %0d we=%0b a=%0d b=%0d c=%0d d=0x%08h -> q_a=0x%08h q_b=0x%08h q_c=0x%08h",
               i, vecs[i].we, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d, q_a, q_b, q_c);
      @(negedge clk);
    end

    // Asynchronous reset between edges clears contents without a clock edge.
    drive(1'b0, 6, 31, 17, 32'd0);
    #1;
    chk("async_pre_q_a", q_a, 32'd39);
    chk("async_pre_q_b", q_b, 32'hA5A5A5A5);
    #1 reset = 1'b1;
    #1;
    chk("async_now_q_a", q_a, 0);
    chk("async_now_q_b", q_b, 0);
    chk("async_now_q_c", q_c, 0);
    $display("async reset mid-cycle -> q_a=0x%08h q_b=0x%08h q_c=0x%08h", q_a, q_b, q_c);

    // A write on an edge while reset is held must be lost.
    drive(1'b1, 6, 31, 6, 32'd55);
    @(posedge clk); #1;
    chk("wr_in_reset_q_a", q_a, 0);
    chk("wr_in_reset_q_c", q_c, 0);
    $display("write during reset c=6 d=55 -> q_c=0x%08h", q_c);

    // The first edge after reset release takes the write.
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_release_pre_q_c", q_c, 0);
    @(posedge clk); #1;
    chk("post_release_q_c", q_c, 32'd55);
    chk("post_release_q_a", q_a, 32'd55);
    chk("post_release_q_b", q_b, 0);
    $display("first write after reset c=6 d=55 -> q_c=0x%08h", q_c);

    @(negedge clk);
    drive(1'b0, 17, 0, 9, 32'd0);
    #1;
    chk("cleared_r17", q_a, 0);
    chk("zero_reg_q_b", q_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
